// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU sequencer: ALU opcodes,
// RV32I major opcodes, FSM states, and the small decode select types.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {ST_IDLE, ST_PASS1, ST_PASS2, ST_HOLD} state_e;
  typedef enum logic [1:0] {ASEL_ZERO, ASEL_RS1, ASEL_PC} asel_e;
  typedef enum logic [1:0] {BSEL_RS2, BSEL_IMM, BSEL_SHAMT, BSEL_FOUR} bsel_e;
  typedef enum logic [1:0] {KIND_ALU, KIND_BRANCH, KIND_JAL, KIND_JALR} kind_e;
  typedef enum logic [1:0] {COND_EQ, COND_NE, COND_LT, COND_GE} cond_e;

  // funct3 to ALU op; alt selects SUB/SRA on the 000/101 slots.
  function automatic logic [4:0] funct3_to_op(input logic [2:0] f3, input logic alt);
    logic [4:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // funct7 is 0000000, or 0100000 only where an alternate op exists.
  function automatic logic funct7_legal(input logic [2:0] f3, input logic [6:0] f7);
    return (f7 == 7'b0000000) ||
           ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
  endfunction

endpackage

// File: rtl/rv32_alu_decode.sv
// Combinational decode of opcode/funct fields into the first ALU pass,
// operand selects, pass count, branch condition and legality.
module rv32_alu_decode
  import alu_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output logic [4:0] op_o,
  output asel_e      a_sel_o,
  output bsel_e      b_sel_o,
  output kind_e      kind_o,
  output cond_e      cond_o,
  output logic       two_pass_o,
  output logic       illegal_o
);

  // Field decode; defaults describe an illegal instruction.
  always_comb begin
    op_o       = ALU_ADD;
    a_sel_o    = ASEL_ZERO;
    b_sel_o    = BSEL_IMM;
    kind_o     = KIND_ALU;
    cond_o     = COND_EQ;
    two_pass_o = 1'b0;
    illegal_o  = 1'b1;
    case (opcode_i)
      OPC_RTYPE: begin
        op_o      = funct3_to_op(funct3_i, funct7_i[5]);
        a_sel_o   = ASEL_RS1;
        b_sel_o   = BSEL_RS2;
        illegal_o = !funct7_legal(funct3_i, funct7_i);
      end
      OPC_IALU: begin
        a_sel_o = ASEL_RS1;
        if ((funct3_i == 3'b001) || (funct3_i == 3'b101)) begin
          op_o      = funct3_to_op(funct3_i, funct7_i[5]);
          b_sel_o   = BSEL_SHAMT;
          illegal_o = !funct7_legal(funct3_i, funct7_i);
        end else begin
          // funct7 here is immediate payload, so ADDI never uses SUB.
          op_o      = funct3_to_op(funct3_i, 1'b0);
          illegal_o = 1'b0;
        end
      end
      OPC_LUI: begin
        illegal_o = 1'b0;
      end
      OPC_AUIPC: begin
        a_sel_o   = ASEL_PC;
        illegal_o = 1'b0;
      end
      OPC_LOAD, OPC_STORE: begin
        a_sel_o   = ASEL_RS1;
        illegal_o = 1'b0;
      end
      OPC_BRANCH: begin
        a_sel_o    = ASEL_RS1;
        b_sel_o    = BSEL_RS2;
        kind_o     = KIND_BRANCH;
        two_pass_o = 1'b1;
        illegal_o  = 1'b0;
        case (funct3_i)
          3'b000:  begin op_o = ALU_SUB;  cond_o = COND_EQ; end
          3'b001:  begin op_o = ALU_SUB;  cond_o = COND_NE; end
          3'b100:  begin op_o = ALU_SLT;  cond_o = COND_LT; end
          3'b101:  begin op_o = ALU_SLT;  cond_o = COND_GE; end
          3'b110:  begin op_o = ALU_SLTU; cond_o = COND_LT; end
          3'b111:  begin op_o = ALU_SLTU; cond_o = COND_GE; end
          default: illegal_o = 1'b1;
        endcase
      end
      OPC_JAL: begin
        a_sel_o    = ASEL_PC;
        b_sel_o    = BSEL_FOUR;
        kind_o     = KIND_JAL;
        two_pass_o = 1'b1;
        illegal_o  = 1'b0;
      end
      OPC_JALR: begin
        a_sel_o    = ASEL_PC;
        b_sel_o    = BSEL_FOUR;
        kind_o     = KIND_JALR;
        two_pass_o = 1'b1;
        illegal_o  = (funct3_i != 3'b000);
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage sequencer: accepts a decoded instruction, runs one or two
// passes through the shared ALU, and holds result/branch/target until taken.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int XLEN_P = XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  logic [XLEN_P-1:0] in_rs1,
  input  logic [XLEN_P-1:0] in_rs2,
  input  logic [XLEN_P-1:0] in_imm,
  input  logic [XLEN_P-1:0] in_pc,
  output logic [XLEN_P-1:0] alu_a,
  output logic [XLEN_P-1:0] alu_b,
  output logic [4:0]      alu_op,
  input  logic [XLEN_P-1:0] alu_y,
  input  logic            alu_zero,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN_P-1:0] out_result,
  output logic            out_branch_taken,
  output logic [XLEN_P-1:0] out_target,
  output logic            out_illegal
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, rs1_q, rs1_d, imm_q, imm_d;
  kind_e       kind_q, kind_d;
  cond_e       cond_q, cond_d;
  logic        two_pass_q, two_pass_d;
  logic [31:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [4:0]  alu_op_q, alu_op_d;
  logic        in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [31:0] res_q, res_d, target_q, target_d;
  logic        taken_q, taken_d, illegal_q, illegal_d;

  logic [4:0]  dec_op_s;
  asel_e       dec_asel_s;
  bsel_e       dec_bsel_s;
  kind_e       dec_kind_s;
  cond_e       dec_cond_s;
  logic        dec_two_pass_s, dec_illegal_s;
  logic [31:0] opa_s, opb_s;
  logic        cond_true_s;

  rv32_alu_decode u_decode (
    .opcode_i   (in_opcode),
    .funct3_i   (in_funct3),
    .funct7_i   (in_funct7),
    .op_o       (dec_op_s),
    .a_sel_o    (dec_asel_s),
    .b_sel_o    (dec_bsel_s),
    .kind_o     (dec_kind_s),
    .cond_o     (dec_cond_s),
    .two_pass_o (dec_two_pass_s),
    .illegal_o  (dec_illegal_s)
  );

  // First-pass operand muxes from the incoming instruction fields.
  always_comb begin
    case (dec_asel_s)
      ASEL_RS1: opa_s = in_rs1;
      ASEL_PC:  opa_s = in_pc;
      default:  opa_s = 32'd0;
    endcase
    case (dec_bsel_s)
      BSEL_RS2:   opb_s = in_rs2;
      BSEL_SHAMT: opb_s = {27'd0, in_imm[4:0]};
      BSEL_FOUR:  opb_s = 32'd4;
      default:    opb_s = in_imm;
    endcase
  end

  // Branch outcome from the PASS1 comparison result.
  always_comb begin
    case (cond_q)
      COND_EQ: cond_true_s = alu_zero;
      COND_NE: cond_true_s = !alu_zero;
      COND_LT: cond_true_s = alu_y[0];
      default: cond_true_s = !alu_y[0];
    endcase
  end

  // Next-state and output-register logic; ALU operands default to zero.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    rs1_d      = rs1_q;
    imm_d      = imm_q;
    kind_d     = kind_q;
    cond_d     = cond_q;
    two_pass_d = two_pass_q;
    res_d      = res_q;
    target_d   = target_q;
    taken_d    = taken_q;
    illegal_d  = illegal_q;
    alu_a_d    = 32'd0;
    alu_b_d    = 32'd0;
    alu_op_d   = ALU_ADD;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          pc_d       = in_pc;
          rs1_d      = in_rs1;
          imm_d      = in_imm;
          kind_d     = dec_kind_s;
          cond_d     = dec_cond_s;
          two_pass_d = dec_two_pass_s;
          res_d      = 32'd0;
          taken_d    = 1'b0;
          if (dec_illegal_s) begin
            state_d   = ST_HOLD;
            target_d  = 32'd0;
            illegal_d = 1'b1;
          end else begin
            state_d   = ST_PASS1;
            target_d  = in_pc + 32'd4;
            illegal_d = 1'b0;
            alu_a_d   = opa_s;
            alu_b_d   = opb_s;
            alu_op_d  = dec_op_s;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PASS1: begin
        if (two_pass_q) begin
          state_d  = ST_PASS2;
          alu_op_d = ALU_ADD;
          alu_b_d  = imm_q;
          if (kind_q == KIND_BRANCH) begin
            taken_d = cond_true_s;
            alu_a_d = pc_q;
            alu_b_d = cond_true_s ? imm_q : 32'd4;
          end else begin
            taken_d = 1'b1;
            res_d   = alu_y;
            alu_a_d = (kind_q == KIND_JALR) ? rs1_q : pc_q;
          end
        end else begin
          state_d = ST_HOLD;
          res_d   = alu_y;
        end
      end
      ST_PASS2: begin
        state_d  = ST_HOLD;
        target_d = (kind_q == KIND_JALR) ? (alu_y & 32'hFFFF_FFFE) : alu_y;
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_HOLD);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= 32'd0;
      rs1_q       <= 32'd0;
      imm_q       <= 32'd0;
      kind_q      <= KIND_ALU;
      cond_q      <= COND_EQ;
      two_pass_q  <= 1'b0;
      alu_a_q     <= 32'd0;
      alu_b_q     <= 32'd0;
      alu_op_q    <= ALU_ADD;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      res_q       <= 32'd0;
      target_q    <= 32'd0;
      taken_q     <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      rs1_q       <= rs1_d;
      imm_q       <= imm_d;
      kind_q      <= kind_d;
      cond_q      <= cond_d;
      two_pass_q  <= two_pass_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      target_q    <= target_d;
      taken_q     <= taken_d;
      illegal_q   <= illegal_d;
    end
  end

  assign in_ready         = in_ready_q;
  assign alu_a            = alu_a_q;
  assign alu_b            = alu_b_q;
  assign alu_op           = alu_op_q;
  assign out_valid        = out_valid_q;
  assign out_result       = res_q;
  assign out_branch_taken = taken_q;
  assign out_target       = target_q;
  assign out_illegal      = illegal_q;

endmodule
